// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction arbiter and the spi_module it drives.
// Contents:
//   WORD_LEN_DEF / CNT_W_DEF : default word width and word-count width
//   state_t, ST_*            : arbiter FSM state encoding
package spi_pkg;

    localparam int WORD_LEN_DEF = 8;
    localparam int CNT_W_DEF    = 5;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_GRANT     = 3'd1;
    localparam state_t ST_KICK      = 3'd2;
    localparam state_t ST_WAIT_WORD = 3'd3;
    localparam state_t ST_FINISH    = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or after the pointer,
// searching upward with wrap-around.
// Ports:
//   i_req   : request vector
//   i_ptr   : index of the highest-priority requester this round
//   o_gnt   : one-hot grant (all zero when nothing requests)
//   o_idx   : index of the granted requester
//   o_valid : at least one request is set
module rr_arbiter
    import spi_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    localparam logic [N_REQ-1:0] GNT_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] w_cand;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Walk the requesters starting at the pointer and keep the first hit.
    always_comb begin
        w_cand  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = IDX_W'((int'(i_ptr) + i) % N_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end else begin
                w_found = w_found;
            end
        end
        o_idx   = w_idx;
        o_valid = w_found;
        if (w_found) begin
            o_gnt = GNT_ONE << w_idx;
        end else begin
            o_gnt = '0;
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one spi_module between N_REQ requesters. Grants round-robin, programs the
// word counts, launches each word with a process_next_word pulse, streams send
// words from the granted requester and returns received words. A per-word
// watchdog aborts a transaction whose word_done never arrives.
// Ports:
//   clk, rst                        : clock, asynchronous active-low reset
//   req_i / req_num_*_i / req_data_i: per-requester request, counts, current send word
//   gnt_o, send_ack_o, done_o, err_o: per-requester grant and 1-cycle status pulses
//   rcv_data_o, rcv_valid_o         : received word and its strobe
//   spi_*                           : connection to spi_module
module spi_txn_arbiter
    import spi_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int WORD_LEN    = WORD_LEN_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*CNT_W-1:0]    req_num_send_i,
    input  logic [N_REQ*CNT_W-1:0]    req_num_rcv_i,
    input  logic [N_REQ*WORD_LEN-1:0] req_data_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [N_REQ-1:0]          send_ack_o,
    output logic [WORD_LEN-1:0]       rcv_data_o,
    output logic                      rcv_valid_o,
    output logic [N_REQ-1:0]          done_o,
    output logic [N_REQ-1:0]          err_o,
    input  logic                      spi_ready_i,
    input  logic                      spi_word_done_i,
    input  logic [WORD_LEN-1:0]       spi_rcv_data_i,
    output logic                      spi_process_next_word_o,
    output logic [WORD_LEN-1:0]       spi_data_send_o,
    output logic [CNT_W-1:0]          spi_num_send_o,
    output logic [CNT_W-1:0]          spi_num_rcv_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_win;
    logic [CNT_W-1:0]   r_send_left;
    logic [CNT_W-1:0]   r_rcv_left;
    logic               r_cur_is_send;
    logic [WD_W-1:0]    r_wd;

    logic [N_REQ-1:0]   w_arb_gnt;
    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_arb_valid;
    logic [CNT_W-1:0]   w_rcv_left_nxt;
    logic               w_more;
    logic               w_launch;

    logic [CNT_W-1:0]    w_num_send [N_REQ];
    logic [CNT_W-1:0]    w_num_rcv  [N_REQ];
    logic [WORD_LEN-1:0] w_data     [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_num_send[g] = req_num_send_i[g*CNT_W +: CNT_W];
        assign w_num_rcv[g]  = req_num_rcv_i[g*CNT_W +: CNT_W];
        assign w_data[g]     = req_data_i[g*WORD_LEN +: WORD_LEN];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req   (req_i),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    // Remaining-word bookkeeping and the decision to launch another word this cycle.
    // A launch happens either straight out of GRANT or on a word_done that leaves work.
    always_comb begin
        if (!r_cur_is_send) begin
            w_rcv_left_nxt = r_rcv_left - CNT_ONE;
        end else begin
            w_rcv_left_nxt = r_rcv_left;
        end
        w_more = (r_send_left != CNT_ZERO) || (w_rcv_left_nxt != CNT_ZERO);
        if (r_state == ST_GRANT) begin
            w_launch = (r_send_left != CNT_ZERO) || (r_rcv_left != CNT_ZERO);
        end else if (r_state == ST_WAIT_WORD) begin
            w_launch = spi_word_done_i && w_more;
        end else begin
            w_launch = 1'b0;
        end
    end

    // Transaction FSM. Word-launch side effects are applied on the edge that enters
    // KICK so that process_next_word, the send word and send_ack appear together
    // one cycle after grant or word_done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state                 <= ST_IDLE;
            r_rr_ptr                <= '0;
            r_win                   <= '0;
            r_send_left             <= '0;
            r_rcv_left              <= '0;
            r_cur_is_send           <= 1'b0;
            r_wd                    <= '0;
            gnt_o                   <= '0;
            send_ack_o              <= '0;
            rcv_data_o              <= '0;
            rcv_valid_o             <= 1'b0;
            done_o                  <= '0;
            err_o                   <= '0;
            spi_process_next_word_o <= 1'b0;
            spi_data_send_o         <= '0;
            spi_num_send_o          <= '0;
            spi_num_rcv_o           <= '0;
        end else begin
            send_ack_o              <= '0;
            rcv_valid_o             <= 1'b0;
            done_o                  <= '0;
            err_o                   <= '0;
            spi_process_next_word_o <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid && spi_ready_i) begin
                        gnt_o          <= w_arb_gnt;
                        r_win          <= w_arb_idx;
                        spi_num_send_o <= w_num_send[w_arb_idx];
                        spi_num_rcv_o  <= w_num_rcv[w_arb_idx];
                        r_send_left    <= w_num_send[w_arb_idx];
                        r_rcv_left     <= w_num_rcv[w_arb_idx];
                        r_rr_ptr       <= (w_arb_idx == IDX_LAST) ? '0 : w_arb_idx + IDX_ONE;
                        r_state        <= ST_GRANT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    r_state <= w_launch ? ST_KICK : ST_FINISH;
                end
                ST_KICK: begin
                    r_wd    <= '0;
                    r_state <= ST_WAIT_WORD;
                end
                ST_WAIT_WORD: begin
                    // word_done is checked first so it beats a same-cycle timeout
                    if (spi_word_done_i) begin
                        if (!r_cur_is_send) begin
                            rcv_data_o  <= spi_rcv_data_i;
                            rcv_valid_o <= 1'b1;
                        end
                        r_rcv_left <= w_rcv_left_nxt;
                        r_state    <= w_more ? ST_KICK : ST_FINISH;
                    end else if (r_wd == WD_LAST) begin
                        err_o       <= gnt_o;
                        gnt_o       <= '0;
                        r_send_left <= '0;
                        r_rcv_left  <= '0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wd <= r_wd + WD_ONE;
                    end
                end
                ST_FINISH: begin
                    done_o  <= gnt_o;
                    gnt_o   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    gnt_o   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_launch) begin
                spi_process_next_word_o <= 1'b1;
                if (r_send_left != CNT_ZERO) begin
                    spi_data_send_o <= w_data[r_win];
                    send_ack_o      <= gnt_o;
                    r_send_left     <= r_send_left - CNT_ONE;
                    r_cur_is_send   <= 1'b1;
                end else begin
                    r_cur_is_send   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
module tb_spi_txn_arbiter;

    localparam int TO = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_i;
    logic [9:0]  req_num_send_i;
    logic [9:0]  req_num_rcv_i;
    logic [15:0] req_data_i;
    logic [1:0]  gnt_o, send_ack_o, done_o, err_o;
    logic [7:0]  rcv_data_o;
    logic        rcv_valid_o;
    logic        spi_ready_i, spi_word_done_i;
    logic [7:0]  spi_rcv_data_i;
    logic        spi_process_next_word_o;
    logic [7:0]  spi_data_send_o;
    logic [4:0]  spi_num_send_o, spi_num_rcv_o;

    always #5 clk = ~clk;

    spi_txn_arbiter #(.N_REQ(2), .WORD_LEN(8), .CNT_W(5), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .req_num_send_i(req_num_send_i),
        .req_num_rcv_i(req_num_rcv_i), .req_data_i(req_data_i), .gnt_o(gnt_o),
        .send_ack_o(send_ack_o), .rcv_data_o(rcv_data_o), .rcv_valid_o(rcv_valid_o),
        .done_o(done_o), .err_o(err_o), .spi_ready_i(spi_ready_i),
        .spi_word_done_i(spi_word_done_i), .spi_rcv_data_i(spi_rcv_data_i),
        .spi_process_next_word_o(spi_process_next_word_o), .spi_data_send_o(spi_data_send_o),
        .spi_num_send_o(spi_num_send_o), .spi_num_rcv_o(spi_num_rcv_o)
    );

    int vectors = 0, miscompares = 0;
    int cyc = 0, n_gnt = 0, n_done = 0, n_err = 0;
    int gnt_cyc, fall_cyc, done_cyc, err_cyc, wd_cyc, pnw_cyc, first_pnw_cyc;
    int pnw_cnt, ack_cnt, wd_cnt = 0, fixed_delay = 0, m_ptr = 0;
    bit hang = 1'b0;
    logic [1:0] gnt_prev = 2'b00, gnt_val, done_val, err_val, ack_val;
    logic [7:0] dq0[$], dq1[$], ex0[$], ex1[$];
    logic [7:0] q_sent[$], q_rcv[$], q_rx[$], rx_script[$];
    int cs[2], cr[2];

    // Round-robin reference: first set bit at or after the pointer, with wrap.
    function automatic int rr_pick(input logic [1:0] m, input int p);
        for (int i = 0; i < 2; i++) begin
            if (m[(p + i) % 2]) return (p + i) % 2;
        end
        return -1;
    endfunction

    task automatic present();
        req_data_i[7:0]  = (dq0.size() > 0) ? dq0[0] : 8'h00;
        req_data_i[15:8] = (dq1.size() > 0) ? dq1[0] : 8'h00;
    endtask

    task automatic set_req(input int k, input int s, input int r);
        cs[k] = s; cr[k] = r;
        if (k == 0) begin
            req_num_send_i[4:0] = 5'(s); req_num_rcv_i[4:0] = 5'(r);
            dq0.delete();
            for (int i = 0; i < s; i++) dq0.push_back(8'($urandom));
            ex0 = dq0;
        end else begin
            req_num_send_i[9:5] = 5'(s); req_num_rcv_i[9:5] = 5'(r);
            dq1.delete();
            for (int i = 0; i < s; i++) dq1.push_back(8'($urandom));
            ex1 = dq1;
        end
        present();
    endtask

    task automatic clr_rec();
        pnw_cnt = 0; ack_cnt = 0; ack_val = 2'b00; first_pnw_cyc = -1;
        gnt_val = 2'b00; done_val = 2'b00; err_val = 2'b00;
        gnt_cyc = -1; fall_cyc = -1; done_cyc = -1; err_cyc = -1; wd_cyc = -1; pnw_cyc = -1;
        q_sent.delete(); q_rcv.delete(); q_rx.delete(); rx_script.delete();
        fixed_delay = 0;
    endtask

    // One clock: sample outputs 1 time unit after the edge, act as requesters and spi_module.
    task automatic cycle();
        logic [7:0] tmp;
        @(posedge clk);
        #1;
        cyc++;
        if (gnt_o != 2'b00 && gnt_prev == 2'b00) begin n_gnt++; gnt_val = gnt_o; gnt_cyc = cyc; end
        if (gnt_o == 2'b00 && gnt_prev != 2'b00) fall_cyc = cyc;
        gnt_prev = gnt_o;
        if (send_ack_o != 2'b00) begin ack_cnt++; ack_val = ack_val | send_ack_o; end
        if (send_ack_o[0] && dq0.size() > 0) tmp = dq0.pop_front();
        if (send_ack_o[1] && dq1.size() > 0) tmp = dq1.pop_front();
        present();
        if (rcv_valid_o) q_rcv.push_back(rcv_data_o);
        if (done_o != 2'b00) begin n_done++; done_val = done_o; done_cyc = cyc; end
        if (err_o != 2'b00) begin n_err++; err_val = err_o; err_cyc = cyc; end
        spi_word_done_i = 1'b0;
        if (wd_cnt > 0) begin
            wd_cnt--;
            if (wd_cnt == 0) begin
                spi_rcv_data_i  = (rx_script.size() > 0) ? rx_script.pop_front() : 8'($urandom);
                spi_word_done_i = 1'b1;
                q_rx.push_back(spi_rcv_data_i);
                wd_cyc = cyc;
            end
        end
        if (spi_process_next_word_o) begin
            pnw_cnt++; pnw_cyc = cyc;
            if (first_pnw_cyc < 0) first_pnw_cyc = cyc;
            q_sent.push_back(spi_data_send_o);
            if (!hang) wd_cnt = (fixed_delay > 0) ? fixed_delay : $urandom_range(3, 1);
        end
    endtask

    task automatic wait_gnt(input int budget, output bit ok);
        int start;
        start = n_gnt; ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (n_gnt != start) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_end(input int budget, output bit ok);
        int start;
        start = n_done + n_err; ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (n_done + n_err != start) begin ok = 1'b1; break; end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0; req_i = 2'b00; spi_word_done_i = 1'b0; wd_cnt = 0; hang = 1'b0; fixed_delay = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; m_ptr = 0; gnt_prev = 2'b00;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({gnt_o, send_ack_o, rcv_data_o, rcv_valid_o, done_o, err_o, spi_process_next_word_o,
             spi_data_send_o, spi_num_send_o, spi_num_rcv_o} !== 39'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: gnt=%b pnw=%b data=%h nums=%0d/%0d, all required 0",
                     gnt_o, spi_process_next_word_o, spi_data_send_o, spi_num_send_o, spi_num_rcv_o);
        end
        rst = 1'b1;
        repeat (4) cycle();
        vectors++;
        if (n_gnt != 0 || gnt_o !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_idle_grant: gnt=%b grants=%0d, required none", gnt_o, n_gnt);
        end
    endtask

    task automatic test_basic();
        bit ok1, ok2;
        clr_rec();
        set_req(0, 1, 2);
        dq0[0] = 8'h0F; ex0 = dq0; present();
        rx_script.push_back(8'h5A); rx_script.push_back(8'hA5); rx_script.push_back(8'h3C);
        req_i = 2'b01;
        wait_gnt(20, ok1);
        req_i = 2'b00;
        wait_end(100, ok2);
        m_ptr = 1;
        vectors++;
        if (!(ok1 && ok2)) begin miscompares++; $display("FAIL basic_bound: gnt_ok=%0d end_ok=%0d, required 1/1", ok1, ok2); end
        vectors++;
        if (gnt_val !== 2'b01) begin miscompares++; $display("FAIL basic_gnt: got %b want 01", gnt_val); end
        vectors++;
        if (first_pnw_cyc - gnt_cyc != 1) begin miscompares++; $display("FAIL basic_gnt_to_pnw: got %0d want 1", first_pnw_cyc - gnt_cyc); end
        vectors++;
        if (pnw_cnt != 3) begin miscompares++; $display("FAIL basic_pnw_count: got %0d want 3", pnw_cnt); end
        vectors++;
        if (ack_cnt != 1 || ack_val !== 2'b01) begin miscompares++; $display("FAIL basic_ack: got %0d x %b want 1 x 01", ack_cnt, ack_val); end
        vectors++;
        if (q_sent.size() < 1 || q_sent[0] !== 8'h0F) begin miscompares++; $display("FAIL basic_send_data: got %h want 0f", (q_sent.size() > 0) ? q_sent[0] : 8'hxx); end
        vectors++;
        if (q_rcv.size() != 2 || q_rcv[0] !== 8'hA5 || q_rcv[1] !== 8'h3C) begin
            miscompares++; $display("FAIL basic_rcv: got %0d words %p want a5,3c", q_rcv.size(), q_rcv);
        end
        vectors++;
        if (done_val !== 2'b01 || done_cyc - wd_cyc != 2) begin
            miscompares++; $display("FAIL basic_done: got %b after %0d want 01 after 2", done_val, done_cyc - wd_cyc);
        end
        vectors++;
        if (fall_cyc != done_cyc) begin miscompares++; $display("FAIL basic_gnt_drop: at %0d want %0d", fall_cyc, done_cyc); end
    endtask

    task automatic test_rr();
        bit ok1, ok2;
        logic [1:0] want;
        apply_reset();
        set_req(0, 1, 0); set_req(1, 1, 0);
        req_i = 2'b11;
        for (int it = 0; it < 4; it++) begin
            clr_rec();
            wait_gnt(20, ok1);
            want = 2'b01 << rr_pick(2'b11, m_ptr);
            m_ptr = (rr_pick(2'b11, m_ptr) + 1) % 2;
            if (it == 3) req_i = 2'b00;
            wait_end(60, ok2);
            vectors++;
            if (!ok1 || !ok2 || gnt_val !== want || gnt_val !== ((it % 2 == 0) ? 2'b01 : 2'b10)) begin
                miscompares++; $display("FAIL rr_grant[%0d]: got %b want %b", it, gnt_val, want);
            end
            vectors++;
            if (done_val !== want) begin miscompares++; $display("FAIL rr_done[%0d]: got %b want %b", it, done_val, want); end
        end
    endtask

    task automatic test_zero();
        bit ok1, ok2;
        int g0;
        clr_rec();
        set_req(1, 0, 0);
        spi_ready_i = 1'b0;
        req_i = 2'b10;
        g0 = n_gnt;
        repeat (6) cycle();
        vectors++;
        if (n_gnt != g0) begin miscompares++; $display("FAIL zero_not_ready: %0d grants while not ready, want 0", n_gnt - g0); end
        spi_ready_i = 1'b1;
        wait_gnt(20, ok1);
        req_i = 2'b00;
        wait_end(20, ok2);
        m_ptr = 0;
        vectors++;
        if (!ok1 || !ok2 || gnt_val !== 2'b10 || done_val !== 2'b10) begin
            miscompares++; $display("FAIL zero_done: gnt=%b done=%b want 10/10", gnt_val, done_val);
        end
        vectors++;
        if (done_cyc - gnt_cyc != 2 || pnw_cnt != 0) begin
            miscompares++; $display("FAIL zero_timing: done after %0d pnw=%0d want 2/0", done_cyc - gnt_cyc, pnw_cnt);
        end
    endtask

    task automatic test_timeout();
        bit ok1, ok2;
        int d0;
        apply_reset();
        clr_rec();
        set_req(0, 0, 1); set_req(1, 0, 0);
        hang = 1'b1;
        req_i = 2'b11;
        d0 = n_done;
        wait_gnt(20, ok1);
        wait_end(TO + 20, ok2);
        vectors++;
        if (!ok1 || !ok2 || gnt_val !== 2'b01 || err_val !== 2'b01 || n_done != d0) begin
            miscompares++; $display("FAIL timeout_err: gnt=%b err=%b dones=%0d want 01/01/0", gnt_val, err_val, n_done - d0);
        end
        vectors++;
        if (err_cyc - pnw_cyc != TO + 1 || fall_cyc != err_cyc) begin
            miscompares++; $display("FAIL timeout_timing: err after %0d drop at %0d want %0d, %0d", err_cyc - pnw_cyc, fall_cyc, TO + 1, err_cyc);
        end
        hang = 1'b0;
        clr_rec();
        wait_gnt(20, ok1);
        req_i = 2'b00;
        wait_end(20, ok2);
        m_ptr = 0;
        vectors++;
        if (!ok1 || !ok2 || gnt_val !== 2'b10 || done_val !== 2'b10) begin
            miscompares++; $display("FAIL timeout_next: gnt=%b done=%b want 10/10", gnt_val, done_val);
        end
    endtask

    task automatic test_timeout_race();
        bit ok1, ok2;
        int e0;
        clr_rec();
        set_req(0, 0, 1);
        fixed_delay = TO;
        e0 = n_err;
        req_i = 2'b01;
        wait_gnt(20, ok1);
        req_i = 2'b00;
        wait_end(TO + 20, ok2);
        m_ptr = 1;
        vectors++;
        if (!ok1 || !ok2 || n_err != e0 || done_val !== 2'b01 || q_rcv.size() != 1 || q_rcv[0] !== q_rx[0]) begin
            miscompares++; $display("FAIL timeout_race: errs=%0d done=%b rcv=%p want 0/01/%p", n_err - e0, done_val, q_rcv, q_rx);
        end
    endtask

    task automatic test_reset_mid();
        bit ok1, ok2;
        clr_rec();
        set_req(1, 0, 2);
        hang = 1'b1;
        req_i = 2'b10;
        wait_gnt(20, ok1);
        req_i = 2'b00;
        repeat (5) cycle();
        rst = 1'b0;
        #1;
        vectors++;
        if ({gnt_o, send_ack_o, rcv_data_o, rcv_valid_o, done_o, err_o, spi_process_next_word_o,
             spi_data_send_o, spi_num_send_o, spi_num_rcv_o} !== 39'd0) begin
            miscompares++; $display("FAIL reset_mid_outputs: gnt=%b num_rcv=%0d want 0/0", gnt_o, spi_num_rcv_o);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; hang = 1'b0; wd_cnt = 0; m_ptr = 0; gnt_prev = 2'b00;
        clr_rec();
        set_req(0, 0, 0); set_req(1, 0, 0);
        req_i = 2'b11;
        wait_gnt(20, ok2);
        req_i = 2'b00;
        wait_end(20, ok1);
        m_ptr = 1;
        vectors++;
        if (!ok2 || gnt_val !== 2'b01) begin miscompares++; $display("FAIL reset_mid_ptr: got %b want 01", gnt_val); end
    endtask

    task automatic test_drop();
        bit ok1, ok2;
        clr_rec();
        set_req(1, 2, 1);
        req_i = 2'b10;
        wait_gnt(20, ok1);
        req_i = 2'b00;
        wait_end(100, ok2);
        m_ptr = 0;
        vectors++;
        if (!ok1 || !ok2 || pnw_cnt != 3 || ack_cnt != 2 || ack_val !== 2'b10) begin
            miscompares++; $display("FAIL drop_words: pnw=%0d acks=%0d x %b want 3/2 x 10", pnw_cnt, ack_cnt, ack_val);
        end
        vectors++;
        if (q_sent.size() != 3 || q_sent[0] !== ex1[0] || q_sent[1] !== ex1[1]) begin
            miscompares++; $display("FAIL drop_send_data: got %p want %p", q_sent, ex1);
        end
        vectors++;
        if (q_rcv.size() != 1 || q_rx.size() != 3 || q_rcv[0] !== q_rx[2] || done_val !== 2'b10) begin
            miscompares++; $display("FAIL drop_rcv_done: rcv=%p done=%b want %p/10", q_rcv, done_val, q_rx);
        end
    endtask

    task automatic test_random();
        bit ok1, ok2;
        logic [1:0] mask;
        logic [7:0] ew[$];
        int w, s, r, bad;
        for (int it = 0; it < 12; it++) begin
            clr_rec();
            mask = 2'($urandom_range(3, 1));
            set_req(0, $urandom_range(3, 0), $urandom_range(3, 0));
            set_req(1, $urandom_range(3, 0), $urandom_range(3, 0));
            req_i = mask;
            wait_gnt(20, ok1);
            req_i = 2'b00;
            wait_end(200, ok2);
            w = rr_pick(mask, m_ptr);
            m_ptr = (w + 1) % 2;
            s = cs[w]; r = cr[w];
            if (w == 0) ew = ex0; else ew = ex1;
            bad = 0;
            if (!ok1 || !ok2) bad++;
            if (gnt_val !== (2'b01 << w) || done_val !== (2'b01 << w)) bad++;
            if (pnw_cnt != s + r || ack_cnt != s) bad++;
            if (s != 0 && ack_val !== (2'b01 << w)) bad++;
            if (q_sent.size() != s + r || q_rcv.size() != r) bad++;
            for (int i = 0; i < s && i < q_sent.size(); i++) if (q_sent[i] !== ew[i]) bad++;
            for (int i = 0; i < r && i < q_rcv.size() && s + i < q_rx.size(); i++) if (q_rcv[i] !== q_rx[s + i]) bad++;
            if ((s + r == 0) ? (done_cyc - gnt_cyc != 2) : (done_cyc - wd_cyc != 2)) bad++;
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL random[%0d]: mask=%b s=%0d r=%0d gnt=%b done=%b pnw=%0d acks=%0d rcv=%0d, want winner %0d, %0d problems",
                         it, mask, s, r, gnt_val, done_val, pnw_cnt, ack_cnt, q_rcv.size(), w, bad);
            end
        end
    endtask

    initial begin
        rst = 1'b0; req_i = 2'b00; req_num_send_i = 10'd0; req_num_rcv_i = 10'd0; req_data_i = 16'd0;
        spi_ready_i = 1'b1; spi_word_done_i = 1'b0; spi_rcv_data_i = 8'd0;
        test_reset();
        test_basic();
        test_rr();
        test_zero();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        test_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_txn_arbiter.md
# spi_txn_arbiter

Round-robin arbiter and sequencer that shares one `spi_module` controller between `N_REQ` requesters (RTC, display, config logic). It grants one requester at a time and programs the word counts. It pulses `process_next_word` once per word, streams send words from the requester, and returns received words. A per-word watchdog aborts transactions that stall.

## Interface
- `N_REQ`, 2, number of requesters (2..4)
- `WORD_LEN`, 8, SPI word width; matches `spi_word_send_len` and `spi_word_rcv_len`
- `CNT_W`, 5, word-count width; matches `num_word_send` and `num_word_rcv`
- `TIMEOUT_CYC`, 4095, maximum `clk` cycles spent waiting for one `word_done`
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-low
- `req_i`  in  N_REQ  level request, one bit per requester
- `req_num_send_i`  in  N_REQ*CNT_W  send-word count; requester k occupies slice [k*CNT_W +: CNT_W]
- `req_num_rcv_i`  in  N_REQ*CNT_W  receive-word count, same packing
- `req_data_i`  in  N_REQ*WORD_LEN  current send word, same packing
- `gnt_o`  out  N_REQ  one-hot grant
- `send_ack_o`  out  N_REQ  1-cycle pulse: current `req_data` slice was consumed; requester presents the next word on the following cycle
- `rcv_data_o`  out  WORD_LEN  received word
- `rcv_valid_o`  out  1  1-cycle strobe qualifying `rcv_data_o` for the granted requester
- `done_o`  out  N_REQ  1-cycle pulse at normal completion
- `err_o`  out  N_REQ  1-cycle pulse at watchdog abort
- `spi_ready_i`  in  1  `spi_module` ready
- `spi_word_done_i`  in  1  `spi_module` word_done pulse
- `spi_rcv_data_i`  in  WORD_LEN  `spi_module` data_word_rcv
- `spi_process_next_word_o`  out  1  1-cycle pulse to `process_next_word`
- `spi_data_send_o`  out  WORD_LEN  to `data_word_send`
- `spi_num_send_o`, `spi_num_rcv_o`  out  CNT_W  to `num_word_send` and `num_word_rcv`

## Operation
- FSM states: IDLE, GRANT, KICK, WAIT_WORD, FINISH.
- IDLE → GRANT when any `req_i` is set and `spi_ready_i`=1. The winner is the first set bit at or after `rr_ptr`, searching upward with wrap.
- GRANT:
  - Set `gnt_o`.
  - Latch the winner's counts into `spi_num_*_o` and the internal `send_left` and `rcv_left`.
  - Set `rr_ptr` = winner+1 mod N_REQ.
  - If `send_left`+`rcv_left`==0, go to FINISH with no SPI activity. Otherwise go to KICK.
- KICK:
  - If `send_left`≠0: latch the winner's `req_data` into `spi_data_send_o`, pulse the winner's `send_ack_o`, and decrement `send_left`.
  - Pulse `spi_process_next_word_o` and clear the watchdog. Go to WAIT_WORD.
- WAIT_WORD on `spi_word_done_i`:
  - If the word was a receive word (`send_left`==0 and the word was not a send), sample `spi_rcv_data_i` into `rcv_data_o`, pulse `rcv_valid_o` the next cycle, and decrement `rcv_left`.
  - If words remain, go to KICK. Otherwise go to FINISH.
- FINISH: pulse `done_o`[winner], clear `gnt_o`, return to IDLE.
- Watchdog: increments every cycle in WAIT_WORD and saturates. On reaching `TIMEOUT_CYC`:
  - pulse `err_o`[winner];
  - clear `gnt_o`, `send_left` and `rcv_left`;
  - go to IDLE without pulsing `done_o`.
- Send words go first, then receive words. A word is a send word if it was launched while `send_left` was nonzero.
- Deasserting `req_i` while granted is ignored; the transaction runs to completion or timeout.
- Requests are arbitrated only in IDLE. Holding `req_i` high after `done_o` makes a new request, which is arbitrated in round-robin order.

## Timing
- Reset: all outputs 0, state IDLE, `rr_ptr`=0, counters 0.
- Request to grant: `gnt_o` is set 1 cycle after IDLE samples `req_i`.
- Grant to first `spi_process_next_word_o`: 1 cycle.
- `word_done` to next `spi_process_next_word_o`: 1 cycle (via KICK).
- `word_done` to `rcv_valid_o`: 1 cycle.
- Last `word_done` to `done_o`: 2 cycles. `gnt_o` drops in the same cycle as `done_o`.
- A `spi_word_done_i` seen outside WAIT_WORD is ignored.
- A `spi_word_done_i` arriving in the same cycle as the timeout wins; the watchdog does not fire.
- The next grant is at least 1 cycle after FINISH, and only once `spi_ready_i`=1.

## Structure
- Package `spi_pkg`: FSM state enum, default `WORD_LEN` and `CNT_W` (shared with `spi_module`).
- Sub-module `rr_arbiter` (request vector and pointer in, one-hot grant and index out), combinational. The FSM registers its result.

## Test plan
- Requester 0 asks for num_send=1 (data 8'h0F) and num_rcv=2, with the SPI model returning 8'hA5 then 8'h3C:
  - 3 `process_next_word` pulses and `send_ack_o`=01 once;
  - `spi_data_send_o`=8'h0F;
  - `rcv_valid_o` twice with 8'hA5 then 8'h3C;
  - `done_o`=01.
- Both requesters held high with 1/0 word counts: grants alternate 01,10,01,10 and each finishes with `done_o`.
- num_send=num_rcv=0: `done_o` 2 cycles after grant, with zero `process_next_word` pulses.
- SPI model never returns `word_done`: `err_o` pulses after `TIMEOUT_CYC` cycles, `gnt_o` clears, and the other requester is then granted.
- `rst` asserted low in WAIT_WORD: all outputs 0 immediately. After release, a fresh request is granted with `rr_ptr`=0 priority.
- Requester 1 drops `req_i` mid-transaction: all words still complete and `done_o`=10.
